// File: rtl/jtag_upload_pkg.sv
// Shared field positions, state type and counter widths for the JTAG upload arbiter.
package jtag_upload_pkg;
  localparam int SEQ_W  = 8;
  localparam int DROP_W = 8;
  localparam int SRC_W  = 2;

  localparam int CTRL_ACK_LSB = 24;
  localparam int CTRL_EN_BIT  = 0;

  localparam int STAT_SEQ_LSB   = 24;
  localparam int STAT_DROP_LSB  = 16;
  localparam int STAT_SRC_LSB   = 4;
  localparam int STAT_EN_BIT    = 1;
  localparam int STAT_VALID_BIT = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    POSTED = 1'b1
  } upState_t;

  function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] val);
    return (val == {DROP_W{1'b1}}) ? val : val + DROP_W'(1);
  endfunction
endpackage

// File: rtl/jtag_rr_arbiter.sv
// Combinational round-robin pick over four requesters, starting just after the last winner.
module jtag_rr_arbiter
  import jtag_upload_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [SRC_W-1:0] last,
  output logic [3:0]       gnt,
  output logic [SRC_W-1:0] idx
);
  logic [SRC_W-1:0] cand_s;
  logic             hit_s;
  logic             found_s;

  // First requesting slot in the order last+1, last+2, ... wins.
  always_comb begin
    gnt     = 4'b0000;
    idx     = 2'd0;
    found_s = 1'b0;
    cand_s  = 2'd0;
    hit_s   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand_s  = last + 2'(i);
      hit_s   = req[cand_s] & ~found_s;
      gnt     = hit_s ? (4'b0001 << cand_s) : gnt;
      idx     = hit_s ? cand_s : idx;
      found_s = found_s | req[cand_s];
    end
  end
endmodule

// File: rtl/jtag_upload_arbiter.sv
// Round-robin upload arbiter: posts one payload at a time to a host-polled JTAG
// data/status register pair and waits for a sequence-matched ack or a timeout.
module jtag_upload_arbiter
  import jtag_upload_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                             iMAIN_CLK,
  input  logic                             iRESET,
  input  logic [NUM_REQ-1:0]               iREQ,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    iREQ_DATA,
  output logic [NUM_REQ-1:0]               oGNT,
  input  logic [WIDTH-1:0]                 iHOST_CTRL,
  output logic [WIDTH-1:0]                 oTX_DATA,
  output logic [WIDTH-1:0]                 oTX_STATUS
);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0]   hostSync1_r;
  logic [WIDTH-1:0]   hostSync2_r;
  upState_t           state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [WIDTH-1:0]   txData_r;
  logic [SEQ_W-1:0]   seq_r;
  logic [DROP_W-1:0]  drop_r;
  logic [SRC_W-1:0]   srcId_r;
  logic [SRC_W-1:0]   lastGrant_r;
  logic               valid_r;
  logic [TIMER_W-1:0] timer_r;

  logic [SEQ_W-1:0]   ackSeq_s;
  logic               enable_s;
  logic               unusedCtrl_s;
  logic [3:0]         rrGnt_s;
  logic [SRC_W-1:0]   rrIdx_s;
  logic [WIDTH-1:0]   status_s;

  assign ackSeq_s     = hostSync2_r[CTRL_ACK_LSB +: SEQ_W];
  assign enable_s     = hostSync2_r[CTRL_EN_BIT];
  assign unusedCtrl_s = ^hostSync2_r;

  jtag_rr_arbiter uRr (
    .req  (iREQ),
    .last (lastGrant_r),
    .gnt  (rrGnt_s),
    .idx  (rrIdx_s)
  );

  // Two-flop synchronizer for the host-written control word.
  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) begin
      hostSync1_r <= {WIDTH{1'b0}};
      hostSync2_r <= {WIDTH{1'b0}};
    end else begin
      hostSync1_r <= iHOST_CTRL;
      hostSync2_r <= hostSync1_r;
    end
  end

  // Grant/post state machine; ack is checked before timeout so a coincident ack wins.
  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) begin
      state_r     <= IDLE;
      gnt_r       <= {NUM_REQ{1'b0}};
      txData_r    <= {WIDTH{1'b0}};
      seq_r       <= {SEQ_W{1'b0}};
      drop_r      <= {DROP_W{1'b0}};
      srcId_r     <= 2'd0;
      lastGrant_r <= 2'd3;
      valid_r     <= 1'b0;
      timer_r     <= {TIMER_W{1'b0}};
    end else begin
      gnt_r <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (enable_s && (iREQ != {NUM_REQ{1'b0}})) begin
            gnt_r       <= rrGnt_s;
            txData_r    <= iREQ_DATA[rrIdx_s];
            srcId_r     <= rrIdx_s;
            lastGrant_r <= rrIdx_s;
            seq_r       <= seq_r + SEQ_W'(1);
            valid_r     <= 1'b1;
            timer_r     <= {TIMER_W{1'b0}};
            state_r     <= POSTED;
          end
        end
        POSTED: begin
          if (ackSeq_s == seq_r) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end else if (timer_r == TIMER_LAST) begin
            valid_r <= 1'b0;
            drop_r  <= satInc(drop_r);
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Status word is pure wiring of registered fields; unused bits stay zero.
  always_comb begin
    status_s = {WIDTH{1'b0}};
    status_s[STAT_SEQ_LSB +: SEQ_W]   = seq_r;
    status_s[STAT_DROP_LSB +: DROP_W] = drop_r;
    status_s[STAT_SRC_LSB +: SRC_W]   = srcId_r;
    status_s[STAT_EN_BIT]             = enable_s;
    status_s[STAT_VALID_BIT]          = valid_r;
  end

  assign oGNT       = gnt_r;
  assign oTX_DATA   = txData_r;
  assign oTX_STATUS = status_s;
endmodule

// File: tb/tb_jtag_upload_arbiter.sv
// Randomized bench for jtag_upload_arbiter against a transaction-level reference model.
module tb_jtag_upload_arbiter;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req;
  logic [3:0][31:0] reqData;
  logic [31:0]      hostCtrl;
  logic [3:0]       gnt;
  logic [31:0]      txData;
  logic [31:0]      txStatus;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          mSeq, mDrop, mSrc, mLast, mInPost;
  bit          mPosted, mValid;
  logic [31:0] mData;
  logic [3:0]  mGnt;
  logic [31:0] hist[$];

  // Stimulus knobs
  bit hostEn, allHeld, reqRandom, randomHost;
  int ackAt;

  always #5 clk = ~clk;

  jtag_upload_arbiter #(.WIDTH(32), .NUM_REQ(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .iMAIN_CLK  (clk),
    .iRESET     (rst),
    .iREQ       (req),
    .iREQ_DATA  (reqData),
    .oGNT       (gnt),
    .iHOST_CTRL (hostCtrl),
    .oTX_DATA   (txData),
    .oTX_STATUS (txStatus)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mSeq = 0; mDrop = 0; mSrc = 0; mLast = 3; mInPost = 0;
    mPosted = 1'b0; mValid = 1'b0; mData = 32'd0; mGnt = 4'd0;
    hist.delete();
  endtask

  // Advance the model by one clock edge; the host word is seen two edges late.
  task automatic modelStep();
    logic [31:0] ctl;
    int win;
    ctl = (hist.size() >= 2) ? hist[hist.size()-2] : 32'd0;
    mGnt = 4'd0;
    if (!mPosted) begin
      if (ctl[0] && req != 4'd0) begin
        win = -1;
        for (int k = 1; k <= 4; k++)
          if (win < 0 && req[(mLast + k) % 4]) win = (mLast + k) % 4;
        mGnt = 4'(1 << win);
        mData = reqData[win];
        mSrc = win; mLast = win;
        mSeq = (mSeq + 1) % 256;
        mValid = 1'b1; mPosted = 1'b1; mInPost = 0;
      end
    end else begin
      mInPost++;
      if (int'(ctl[31:24]) == mSeq) begin
        mPosted = 1'b0; mValid = 1'b0;
      end else if (mInPost == TIMEOUT) begin
        mPosted = 1'b0; mValid = 1'b0;
        if (mDrop < 255) mDrop++;
      end
    end
    hist.push_back(hostCtrl);
    if (hist.size() > 3) void'(hist.pop_front());
  endtask

  task automatic driveHost();
    int ackVal;
    ackVal = (mPosted && mInPost >= ackAt) ? mSeq : (mSeq + 255) % 256;
    hostCtrl = {8'(ackVal), 23'd0, hostEn};
  endtask

  task automatic tick();
    logic [31:0] h;
    logic [31:0] expStat;
    bit expEn;
    modelStep();
    @(posedge clk); #1;
    expEn = 1'b0;
    if (hist.size() >= 2) begin
      h = hist[hist.size()-2];
      expEn = h[0];
    end
    expStat = (32'(mSeq) << 24) | (32'(mDrop) << 16) | (32'(mSrc) << 4) |
              (32'(expEn) << 1) | 32'(mValid);
    checkVal("gnt", {28'd0, gnt}, {28'd0, mGnt});
    checkVal("txData", txData, mData);
    checkVal("status", txStatus, expStat);
    if (randomHost) begin
      if (mGnt != 4'd0) ackAt = $urandom_range(0, 20);
      if ($urandom_range(0, 15) == 0) hostEn = ~hostEn;
    end
    for (int i = 0; i < 4; i++) begin
      if (mGnt[i]) begin
        if (!allHeld) req[i] = 1'b0;
      end else if (reqRandom && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        reqData[i] = $urandom;
      end
    end
    driveHost();
  endtask

  // Must be called straight after tick(): asserts reset between edges.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    checkVal("rstGnt", {28'd0, gnt}, 32'd0);
    checkVal("rstData", txData, 32'd0);
    checkVal("rstStatus", txStatus, 32'd0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic postOne(input int who);
    req[who] = 1'b1;
    reqData[who] = $urandom;
  endtask

  initial begin
    int order[$];
    int expOrder[5];
    int seen, waitCnt;
    req = 4'd0; reqData = '{default: 32'd0}; hostCtrl = 32'd0;
    hostEn = 1'b0; allHeld = 1'b0; reqRandom = 1'b0; randomHost = 1'b0; ackAt = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkVal("initGnt", {28'd0, gnt}, 32'd0);
    checkVal("initData", txData, 32'd0);
    checkVal("initStatus", txStatus, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Single request
    hostEn = 1'b1; ackAt = 1000; driveHost();
    repeat (3) tick();
    req[0] = 1'b1; reqData[0] = 32'hDEADBEEF;
    tick();
    checkVal("singleGnt", {28'd0, gnt}, 32'd1);
    checkVal("singleData", txData, 32'hDEADBEEF);
    checkVal("singleSeq", {24'd0, txStatus[31:24]}, 32'd1);
    checkVal("singleSrc", {30'd0, txStatus[5:4]}, 32'd0);
    checkVal("singleValid", {31'd0, txStatus[0]}, 32'd1);
    tick();
    checkVal("gntPulse", {28'd0, gnt}, 32'd0);
    ackAt = 0; driveHost();
    repeat (3) tick();
    checkVal("ackClears", {31'd0, txStatus[0]}, 32'd0);

    // Fairness from reset
    doReset();
    hostEn = 1'b1; ackAt = 0; driveHost();
    repeat (3) tick();
    allHeld = 1'b1; req = 4'hF;
    for (int i = 0; i < 4; i++) reqData[i] = $urandom;
    expOrder = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick();
      for (int i = 0; i < 4; i++) if (gnt[i]) order.push_back(i);
    end
    checkVal("rrCount", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      checkVal($sformatf("rrOrder%0d", i), 32'(order[i]), 32'(expOrder[i]));
    allHeld = 1'b0; req = 4'd0;
    repeat (6) tick();

    // Timeout, ack/timeout coincidence, late ack, saturation
    ackAt = 1000; driveHost();
    postOne(1);
    tick();
    repeat (15) tick();
    checkVal("toStillValid", {31'd0, txStatus[0]}, 32'd1);
    tick();
    checkVal("toValid", {31'd0, txStatus[0]}, 32'd0);
    checkVal("toDrop1", {24'd0, txStatus[23:16]}, 32'd1);
    ackAt = 13; driveHost(); postOne(2);
    repeat (17) tick();
    checkVal("coincValid", {31'd0, txStatus[0]}, 32'd0);
    checkVal("coincDrop", {24'd0, txStatus[23:16]}, 32'd1);
    ackAt = 14; driveHost(); postOne(3);
    repeat (17) tick();
    checkVal("lateAckDrop", {24'd0, txStatus[23:16]}, 32'd2);
    ackAt = 1000; driveHost();
    for (int n = 0; n < 298; n++) begin
      postOne($urandom_range(0, 3));
      repeat (17) tick();
    end
    checkVal("dropSat", {24'd0, txStatus[23:16]}, 32'd255);

    // Sequence wrap and stale ack
    doReset();
    hostEn = 1'b1; ackAt = 0; driveHost();
    repeat (3) tick();
    for (int n = 0; n < 256; n++) begin
      postOne($urandom_range(0, 3));
      repeat (4) tick();
    end
    checkVal("seqWrap", {24'd0, txStatus[31:24]}, 32'd0);
    checkVal("wrapValid", {31'd0, txStatus[0]}, 32'd0);
    ackAt = 6; driveHost(); postOne(0);
    tick();
    checkVal("post257Seq", {24'd0, txStatus[31:24]}, 32'd1);
    repeat (5) tick();
    checkVal("staleIgnored", {31'd0, txStatus[0]}, 32'd1);
    repeat (5) tick();
    checkVal("ackAccepted", {31'd0, txStatus[0]}, 32'd0);
    checkVal("noDropWrap", {24'd0, txStatus[23:16]}, 32'd0);

    // Random traffic with random ack timing and enable toggling
    reqRandom = 1'b1; randomHost = 1'b1; hostEn = 1'b1;
    repeat (1500) tick();
    reqRandom = 1'b0; randomHost = 1'b0;

    // Reset mid-post, then grant only after enable resynchronizes
    hostEn = 1'b1; ackAt = 1000; driveHost();
    req = 4'd0; postOne(2);
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      tick();
      if (mGnt[2]) seen = 1;
    end
    checkVal("midPostReached", 32'(seen), 32'd1);
    repeat (3) tick();
    doReset();
    hostEn = 1'b0; driveHost(); postOne(2);
    for (int c = 0; c < 6; c++) begin
      tick();
      checkVal("noGntDisabled", {28'd0, gnt}, 32'd0);
    end
    hostEn = 1'b1; driveHost();
    waitCnt = 0; seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      tick();
      if (gnt != 4'd0) begin
        seen = 1; waitCnt = c;
        checkVal("postRstGnt", {28'd0, gnt}, 32'h4);
      end
    end
    checkVal("postRstLatency", 32'(waitCnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
